mod_reduce_seq: RTL

Sequential, parametrised modular reducer. It computes `in_data mod MOD` for a wide operand by consuming one `DIGIT_W`-bit digit per cycle, MSB digit first, using Horner reduction. Each step uses a constant shift-residue ROM and one conditional subtract. It is the iterative, area-lean successor to the per-chunk combinational residue LUTs in the modular calculator (default MOD 997, 300-bit operand, 6-bit digits), and it adds a ready/valid handshake on both sides.

---
 rtl/mod_calc_pkg.sv | 14 +
 rtl/mod_shift_rom.sv | 15 +
 rtl/mod_reduce_seq.sv | 76 +++++++
 3 files changed

// File: rtl/mod_calc_pkg.sv
// mod_calc_pkg: shared FSM state, digit-count and shift-residue helpers for the modular reducer.
package mod_calc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int calc_ndig(input int in_w, input int digit_w);
    return (in_w + digit_w - 1) / digit_w;
  endfunction
  function automatic int shift_residue(input int a, input int digit_w, input int m);
    return int'((longint'(a) << digit_w) % longint'(m));
  endfunction
  // One conditional subtract per step only works while a digit can never exceed MOD.
  function automatic bit params_ok(input int m, input int digit_w, input int out_w);
    return m >= 2 && (1 << digit_w) <= m && m < (1 << out_w);
  endfunction
endpackage

// File: rtl/mod_shift_rom.sv
// mod_shift_rom: constant table rom[a] = (a * 2^DIGIT_W) mod MOD, built at elaboration.
module mod_shift_rom import mod_calc_pkg::*; #(
  parameter int MOD = 997,
  parameter int DIGIT_W = 6,
  parameter int OUT_W = 10
) (
  input  logic [OUT_W-1:0] addr,
  output logic [OUT_W-1:0] data
);
  logic [OUT_W-1:0] rom [MOD];
  for (genvar a = 0; a < MOD; a++) begin : g_rom
    assign rom[a] = OUT_W'(shift_residue(a, DIGIT_W, MOD));
  end
  assign data = (int'(addr) < MOD) ? rom[addr] : '0;
endmodule

// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: digit-serial Horner reduction of in_data mod MOD with ready/valid on both sides.
module mod_reduce_seq import mod_calc_pkg::*; #(
  parameter int MOD = 997,
  parameter int IN_W = 300,
  parameter int DIGIT_W = 6,
  localparam int OUT_W = $clog2(MOD),
  localparam int NDIG = calc_ndig(IN_W, DIGIT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_res,
  output logic             busy
);
  localparam int PW = NDIG * DIGIT_W;
  localparam int CW = $clog2(NDIG + 1);
  if (!params_ok(MOD, DIGIT_W, OUT_W)) begin : g_bad_params
    $error("mod_reduce_seq: parameters need MOD >= 2 and 2^DIGIT_W <= MOD < 2^OUT_W");
  end
  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d, rom_data;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    sr_q, sr_d;
  logic [OUT_W:0]   s;
  mod_shift_rom #(.MOD(MOD), .DIGIT_W(DIGIT_W), .OUT_W(OUT_W)) u_rom (
    .addr(acc_q),
    .data(rom_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    s       = (OUT_W+1)'(rom_data) + (OUT_W+1)'(sr_q[PW-1 -: DIGIT_W]);
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        acc_d   = '0;
        cnt_d   = CW'(NDIG - 1);
        sr_d    = PW'(in_data);
      end
      RUN: begin
        acc_d   = (s >= (OUT_W+1)'(MOD)) ? OUT_W'(s - (OUT_W+1)'(MOD)) : OUT_W'(s);
        sr_d    = sr_q << DIGIT_W;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? DONE : RUN;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Partial accumulator values are masked so only a finished residue is ever visible.
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    out_res   = out_valid ? acc_q : '0;
    busy      = state_q != IDLE;
  end
endmodule
